// File: rtl/l2_bus_pkg.sv
// Shared types, opcode constants and saturating-counter helpers for the
// L2 bus request decoder.
package l2_bus_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned ERR_W   = 16;

  // Values match the command numbers used in the L2 trace files
  typedef enum logic [OP_W-1:0] {
    DATA_READ        = 3'd0,
    DATA_WRITE       = 3'd1,
    INSTR_FETCH      = 3'd2,
    SNOOP_INVALIDATE = 3'd3,
    SNOOP_READ       = 3'd4,
    SNOOP_WRITE      = 3'd5,
    SNOOP_RWIM       = 3'd6
  } op_t;

  localparam logic [15:0] L1_DR = 16'h4452;
  localparam logic [15:0] L1_DW = 16'h4457;
  localparam logic [15:0] L1_IR = 16'h4952;
  localparam logic [7:0]  SN_I  = 8'h49;
  localparam logic [7:0]  SN_R  = 8'h52;
  localparam logic [7:0]  SN_W  = 8'h57;
  localparam logic [7:0]  SN_M  = 8'h4D;

  typedef struct packed {
    op_t               op;
    logic [ADDR_W-1:0] address;
    logic              snoop;
  } req_t;

  function automatic logic [CNT_W-1:0] sat_inc32(logic [CNT_W-1:0] v, logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  function automatic logic [ERR_W-1:0] sat_add16(logic [ERR_W-1:0] v, logic [1:0] inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, v} + (ERR_W + 1)'(inc);
    return sum[ERR_W] ? '1 : sum[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/l2_bus_request_decoder_if.sv
// Request-side bus bundle: L1/snoop strobed inputs, the head handshake
// towards the L2 controller, and the statistics outputs.
interface l2_bus_request_decoder_if #(
  parameter int unsigned addressSize = 64
);
  logic [255:0]             L1Bus;
  logic [15:0]              L1OperationBus;
  logic                     l1Valid;
  logic [511:0]             sharedBus;
  logic [7:0]               sharedOperationBus;
  logic                     snoopValid;
  logic                     reqValid;
  logic                     reqReady;
  logic [2:0]               reqOp;
  logic [addressSize-1:0]   reqAddress;
  logic                     reqSnoop;
  logic                     full;
  logic [31:0]              readCount;
  logic [31:0]              writeCount;
  logic [31:0]              fetchCount;
  logic [31:0]              snoopCount;
  logic [15:0]              dropCount;
  logic [15:0]              illegalCount;

  modport master (
    output L1Bus, L1OperationBus, l1Valid, sharedBus, sharedOperationBus,
           snoopValid, reqReady,
    input  reqValid, reqOp, reqAddress, reqSnoop, full, readCount,
           writeCount, fetchCount, snoopCount, dropCount, illegalCount
  );

  modport slave (
    input  L1Bus, L1OperationBus, l1Valid, sharedBus, sharedOperationBus,
           snoopValid, reqReady,
    output reqValid, reqOp, reqAddress, reqSnoop, full, readCount,
           writeCount, fetchCount, snoopCount, dropCount, illegalCount
  );
endinterface

// File: rtl/l2_req_fifo.sv
// Dual-push, single-pop FIFO; push_a lands ahead of push_b in the same cycle.
// The caller guarantees that pushes never exceed free_count plus a same-edge pop.
module l2_req_fifo #(
  parameter int unsigned depth = 4,
  parameter type entry_t = logic
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_a,
  input  entry_t                   data_a,
  input  logic                     push_b,
  input  entry_t                   data_b,
  input  logic                     pop,
  output logic                     head_valid,
  output entry_t                   head,
  output logic [$clog2(depth):0]   free_count
);
  localparam int unsigned PW    = $clog2(depth);
  localparam int unsigned PTR_W = PW + 1;

  entry_t           mem [depth];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] count;
  logic [PW-1:0]    idx_a;
  logic [PW-1:0]    idx_b;
  logic             do_pop;

  assign count      = wptr - rptr;
  assign head_valid = (count != '0);
  assign free_count = PTR_W'(depth) - count;
  assign head       = mem[rptr[PW-1:0]];
  assign do_pop     = pop && head_valid;
  assign idx_a      = wptr[PW-1:0];
  assign idx_b      = push_a ? idx_a + PW'(1) : idx_a;

  // Storage is cleared on reset so the head fields read zero afterwards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem  <= '{default: '0};
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_a) mem[idx_a] <= data_a;
      if (push_b) mem[idx_b] <= data_b;
      wptr <= wptr + PTR_W'(push_a) + PTR_W'(push_b);
      if (do_pop) rptr <= rptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/l2_bus_request_decoder.sv
// Decodes L1 and snoop bus strobes into queued L2 requests, presents the
// queue head on a valid/ready handshake and keeps saturating statistics.
module l2_bus_request_decoder
  import l2_bus_pkg::*;
#(
  parameter int unsigned addressSize = 64,
  parameter int unsigned depth       = 4,
  parameter bit          stats       = 1'b1
) (
  input logic                clk,
  input logic                reset,
  l2_bus_request_decoder_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(depth) + 1;

  op_t              l1_op;
  op_t              sn_op;
  logic             l1_known;
  logic             sn_known;
  logic             l1_req;
  logic             sn_req;
  logic             accept_l;
  logic             accept_s;
  logic             pop;
  logic [1:0]       drop_n;
  logic [1:0]       illegal_n;
  logic [PTR_W-1:0] free_count;
  logic [PTR_W-1:0] free_after;
  req_t             l1_entry;
  req_t             sn_entry;
  req_t             head;
  logic             head_valid;
  logic             unused_hi;

  logic [CNT_W-1:0] read_cnt, write_cnt, fetch_cnt, snoop_cnt;
  logic [ERR_W-1:0] drop_cnt, illegal_cnt;

  // Opcode decode for both buses
  always_comb begin
    l1_op    = DATA_READ;
    l1_known = 1'b1;
    sn_op    = SNOOP_INVALIDATE;
    sn_known = 1'b1;
    case (bus.L1OperationBus)
      L1_DR:   l1_op = DATA_READ;
      L1_DW:   l1_op = DATA_WRITE;
      L1_IR:   l1_op = INSTR_FETCH;
      default: l1_known = 1'b0;
    endcase
    case (bus.sharedOperationBus)
      SN_I:    sn_op = SNOOP_INVALIDATE;
      SN_R:    sn_op = SNOOP_READ;
      SN_W:    sn_op = SNOOP_WRITE;
      SN_M:    sn_op = SNOOP_RWIM;
      default: sn_known = 1'b0;
    endcase
  end

  assign l1_req    = bus.l1Valid && l1_known;
  assign sn_req    = bus.snoopValid && sn_known;
  assign illegal_n = {1'b0, bus.l1Valid && !l1_known} + {1'b0, bus.snoopValid && !sn_known};

  assign l1_entry = '{op: l1_op, address: ADDR_W'(bus.L1Bus[addressSize-1:0]), snoop: 1'b0};
  assign sn_entry = '{op: sn_op, address: ADDR_W'(bus.sharedBus[addressSize-1:0]), snoop: 1'b1};

  // Snoop takes the first free slot; the L1 entry is dropped first when short
  assign pop        = head_valid && bus.reqReady;
  assign free_after = free_count + PTR_W'(pop);
  assign accept_s   = sn_req && (free_after >= PTR_W'(1));
  assign accept_l   = l1_req && (free_after >= (accept_s ? PTR_W'(2) : PTR_W'(1)));
  assign drop_n     = {1'b0, sn_req && !accept_s} + {1'b0, l1_req && !accept_l};

  l2_req_fifo #(
    .depth   (depth),
    .entry_t (req_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_a     (accept_s || accept_l),
    .data_a     (accept_s ? sn_entry : l1_entry),
    .push_b     (accept_s && accept_l),
    .data_b     (l1_entry),
    .pop        (pop),
    .head_valid (head_valid),
    .head       (head),
    .free_count (free_count)
  );

  generate
    if (stats) begin : g_stats
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          read_cnt    <= '0;
          write_cnt   <= '0;
          fetch_cnt   <= '0;
          snoop_cnt   <= '0;
          drop_cnt    <= '0;
          illegal_cnt <= '0;
        end else begin
          read_cnt    <= sat_inc32(read_cnt,  accept_l && (l1_op == DATA_READ));
          write_cnt   <= sat_inc32(write_cnt, accept_l && (l1_op == DATA_WRITE));
          fetch_cnt   <= sat_inc32(fetch_cnt, accept_l && (l1_op == INSTR_FETCH));
          snoop_cnt   <= sat_inc32(snoop_cnt, accept_s);
          drop_cnt    <= sat_add16(drop_cnt, drop_n);
          illegal_cnt <= sat_add16(illegal_cnt, illegal_n);
        end
      end
    end else begin : g_no_stats
      assign read_cnt    = '0;
      assign write_cnt   = '0;
      assign fetch_cnt   = '0;
      assign snoop_cnt   = '0;
      assign drop_cnt    = '0;
      assign illegal_cnt = '0;
    end
  endgenerate

  assign bus.reqValid     = head_valid;
  assign bus.reqOp        = head.op;
  assign bus.reqAddress   = head.address[addressSize-1:0];
  assign bus.reqSnoop     = head.snoop;
  assign bus.full         = free_count < PTR_W'(2);
  assign bus.readCount    = read_cnt;
  assign bus.writeCount   = write_cnt;
  assign bus.fetchCount   = fetch_cnt;
  assign bus.snoopCount   = snoop_cnt;
  assign bus.dropCount    = drop_cnt;
  assign bus.illegalCount = illegal_cnt;

  assign unused_hi = ^{bus.L1Bus[255:addressSize], bus.sharedBus[511:addressSize]};

endmodule

// File: doc/l2_bus_request_decoder.md
# l2_bus_request_decoder

Receiving end of the L1 and snoop request buses feeding the L2 cache model. Samples strobed requests from the L1 bus (`DR`/`DW`/`IR`) and the shared snoop bus (`I`/`R`/`W`/`M`), decodes the ASCII operation codes into a 3-bit operation enum, and queues them in order in a small FIFO. Presents the queue head to the L2 cache controller over a valid/ready handshake. Keeps per-class statistics and error counters.

## Interface
- `addressSize`, 64: request address width; taken from the low bits of each bus.
- `depth`, 4: FIFO entries; power of two, ≥2.
- `stats`, 1: 1 = statistics counters live; 0 = counters tied to 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `L1Bus`  in  256  L1 address; only `[addressSize-1:0]` used.
- `L1OperationBus`  in  16  two-character ASCII L1 operation.
- `l1Valid`  in  1  one-cycle strobe: L1 request present this cycle.
- `sharedBus`  in  512  snoop address; only `[addressSize-1:0]` used.
- `sharedOperationBus`  in  8  one-character ASCII snoop operation.
- `snoopValid`  in  1  one-cycle strobe: snoop present this cycle.
- `reqValid`  out  1  FIFO head valid.
- `reqReady`  in  1  controller accepts the head.
- `reqOp`  out  3  decoded operation of the head.
- `reqAddress`  out  addressSize  head address.
- `reqSnoop`  out  1  head originated on the shared bus.
- `full`  out  1  fewer than 2 free entries.
- `readCount`, `writeCount`, `fetchCount`, `snoopCount`  out  32 each  accepted-request counters.
- `dropCount`, `illegalCount`  out  16 each  error counters.

## Operation
- L1 decode: 16'h4452 "DR" → 0; 16'h4457 "DW" → 1; 16'h4952 "IR" → 2.
- Snoop decode: 8'h49 "I" → 3; 8'h52 "R" → 4; 8'h57 "W" → 5; 8'h4D "M" → 6.
- Any other code while its valid is high is illegal:
  - not enqueued;
  - `illegalCount` += 1, or += 2 if both buses are illegal in the same cycle.
- Both valids in one cycle: both are enqueued in that cycle, snoop entry ahead of the L1 entry.
- Capacity: free entries after this cycle's pop (a pop on the same edge frees one slot).
  - Entries that do not fit are dropped, L1 entry first.
  - `dropCount` += number dropped.
- Pop: when `reqValid && reqReady`. Push and pop may happen on the same edge. Occupancy wraps via pointers with one extra bit.
- Counters:
  - increment on acceptance into the FIFO, not on pop;
  - `readCount` counts op 0, `writeCount` op 1, `fetchCount` op 2, `snoopCount` ops 3–6;
  - all counters saturate at all-ones.
- `reqOp`, `reqAddress` and `reqSnoop` are don't-care while `reqValid` = 0.
- `reqReady` high with the FIFO empty has no effect.

## Timing
- Reset (asynchronous, immediate): FIFO emptied, `reqValid` = 0, `full` = 0, all counters 0, `reqOp` = 0, `reqAddress` = 0, `reqSnoop` = 0.
- Reset mid-operation discards all queued entries. There is no partial drain.
- Latency: strobe sampled at edge N → `reqValid` high after edge N. No combinational bypass from inputs to outputs.
- `reqValid` and head fields are registered, driven from FIFO storage.
- `full` updates after the edge that changes occupancy.
- Sources must not strobe while `full`; if they do, the drop rules apply.
- Counter values reflect acceptances through the previous edge.

## Structure
- Package `l2_bus_pkg`:
  - `op_t` enum (`DATA_READ`=0 … `SNOOP_RWIM`=6, values matching trace command numbers);
  - ASCII opcode constants;
  - `req_t` struct {op, address, snoop}.
- Sub-module `l2_req_fifo`: dual-push, single-pop FIFO, parameterised on `depth` and entry type. Exposes free-entry count.
- Top level holds decode, push arbitration and counters.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → all outputs read 0 immediately. Deassert, idle 5 cycles → `reqValid` stays 0.
- Single request: `l1Valid` with "DR" and address 64'h1000 at edge N → after edge N, `reqValid`=1, `reqOp`=0, `reqAddress`=64'h1000, `reqSnoop`=0. `reqReady`=1 → empty next cycle; `readCount`=1.
- Simultaneous: snoop "M" at 64'hA0 and L1 "DW" at 64'hB0 in one cycle → head is op 6 / 64'hA0 / snoop=1, then op 1 / 64'hB0. `snoopCount`=1, `writeCount`=1.
- Overflow (`depth`=4, `reqReady`=0):
  - four "IR" strobes → `full`=1 after the third;
  - fifth strobe → dropped, `dropCount`=1, `fetchCount`=4;
  - drain → addresses return in order.
- Illegal code: L1 code 16'h5858 with `l1Valid` → no enqueue, `illegalCount`=1, all other counters unchanged.
- Push/pop same edge: FIFO full (4 entries), `reqReady`=1, and a snoop "I" strobe → entry accepted, occupancy stays 4, `dropCount` unchanged.
